// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel de-interleaver: FSM state encoding and plane sizing.
package pixel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RA,
        RB,
        RC,
        WR,
        WG,
        WB,
        DONE
    } state_e;

    // Words per colour plane; each planar word packs two pixels.
    function automatic int unsigned plane_words(input int unsigned w, input int unsigned h);
        return (w * h) / 2;
    endfunction

endpackage

// File: rtl/deinterleave_datapath.sv
// Pair counter, source latches, address generation and write-data muxing for pixel_deinterleave.
// PIXEL_DEINTERLEAVE_BGR_EN selects B,G,R source order (WR and WB write targets swap planes).
module deinterleave_datapath
    import pixel_pkg::*;
#(
    parameter int unsigned ADDR_INTERLEAVED = 115200,
    parameter int unsigned ADDR_PLANAR      = 0,
    parameter int unsigned P                = 38400,
    parameter int unsigned DW               = 16,
    parameter int unsigned AW               = 18
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  state_e        state_i,
    input  state_e        state_d_i,
    input  logic [DW-1:0] rdata_i,
    output logic          last_pair_o,
    output logic [AW-1:0] raddr_o,
    output logic [AW-1:0] waddr_o,
    output logic [DW-1:0] wdata_o
);

    localparam int unsigned KW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned BW = DW / 2;
    localparam logic [AW-1:0] BASE_I = AW'(ADDR_INTERLEAVED);
    localparam logic [AW-1:0] BASE_P = AW'(ADDR_PLANAR);
    localparam logic [AW-1:0] OFS_WG = AW'(P);
    localparam logic [KW-1:0] K_LAST = KW'(P - 1);

    // The WR/WB write data is fixed by when bytes arrive; BGR order only changes which plane each lands in.
`ifdef PIXEL_DEINTERLEAVE_BGR_EN
    localparam logic [AW-1:0] OFS_WR = AW'(2 * P);
    localparam logic [AW-1:0] OFS_WB = AW'(0);
`else
    localparam logic [AW-1:0] OFS_WR = AW'(0);
    localparam logic [AW-1:0] OFS_WB = AW'(2 * P);
`endif

    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] k_ext;
    logic [DW-1:0] s0_q;
    logic [BW-1:0] s1_hi_q;
    logic [BW-1:0] s2_lo_q;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    assign last_pair_o = (k_q == K_LAST);
    assign raddr_o     = raddr_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;

    // Pair counter: cleared while idle, advances after each pair but saturates at the last one.
    always_comb begin
        k_d = k_q;
        if (state_i == IDLE) begin
            k_d = '0;
        end else if ((state_i == WB) && (k_q != K_LAST)) begin
            k_d = k_q + KW'(1);
        end
    end

    assign k_ext = AW'(k_d);

    // Registered outputs are loaded from next-cycle state; write bytes still on rdata are taken directly.
    always_comb begin
        raddr_d = BASE_I + k_ext + k_ext + k_ext;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_d_i)
            RB: raddr_d = BASE_I + k_ext + k_ext + k_ext + AW'(1);
            RC: raddr_d = BASE_I + k_ext + k_ext + k_ext + AW'(2);
            WR: begin
                waddr_d = BASE_P + k_ext + OFS_WR;
                wdata_d = {s0_q[DW-1:BW], rdata_i[BW-1:0]};
            end
            WG: begin
                waddr_d = BASE_P + k_ext + OFS_WG;
                wdata_d = {s0_q[BW-1:0], rdata_i[DW-1:BW]};
            end
            WB: begin
                waddr_d = BASE_P + k_ext + OFS_WB;
                wdata_d = {s1_hi_q, s2_lo_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            k_q     <= '0;
            s0_q    <= '0;
            s1_hi_q <= '0;
            s2_lo_q <= '0;
            raddr_q <= BASE_I;
            waddr_q <= BASE_P;
            wdata_q <= '0;
        end else begin
            k_q     <= k_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            if (state_i == RB) s0_q    <= rdata_i;
            if (state_i == RC) s1_hi_q <= rdata_i[DW-1:BW];
            if (state_i == WR) s2_lo_q <= rdata_i[BW-1:0];
        end
    end

endmodule

// File: rtl/pixel_deinterleave.sv
// Converts an interleaved RGB image in SRAM into three planar images, six cycles per pixel pair.
// Define PIXEL_DEINTERLEAVE_BGR_EN for a B,G,R ordered source (handled in deinterleave_datapath).
module pixel_deinterleave
    import pixel_pkg::*;
#(
    parameter int unsigned ADDR_INTERLEAVED = 115200,
    parameter int unsigned ADDR_PLANAR      = 0,
    parameter int unsigned W                = 320,
    parameter int unsigned H                = 240,
    parameter int unsigned DW               = 16,
    parameter int unsigned AW               = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          wr_enable
);

    localparam int unsigned P = plane_words(W, H);

    state_e state_q, state_d;
    logic   last_pair;
    logic   wr_en_q, wr_en_d;
    logic   done_q, done_d;

    // Reset masks the strobes in the very cycle it is raised, so an aborted pair never writes.
    assign wr_enable = wr_en_q & ~reset;
    assign done      = done_q & ~reset;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RA;
            RA:      state_d = RB;
            RB:      state_d = RC;
            RC:      state_d = WR;
            WR:      state_d = WG;
            WG:      state_d = WB;
            WB:      state_d = last_pair ? DONE : RA;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wr_en_d = (state_d == WR) || (state_d == WG) || (state_d == WB);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
        end
    end

    deinterleave_datapath #(
        .ADDR_INTERLEAVED (ADDR_INTERLEAVED),
        .ADDR_PLANAR      (ADDR_PLANAR),
        .P                (P),
        .DW               (DW),
        .AW               (AW)
    ) u_datapath (
        .clk_i       (clk),
        .reset_i     (reset),
        .state_i     (state_q),
        .state_d_i   (state_d),
        .rdata_i     (rdata),
        .last_pair_o (last_pair),
        .raddr_o     (raddr),
        .waddr_o     (waddr),
        .wdata_o     (wdata)
    );

endmodule

// File: tb/tb_pixel_deinterleave.sv
// Directed bench for pixel_deinterleave on a 4x2 image (four pixel pairs) with a one-cycle-latency SRAM.
module tb_pixel_deinterleave;

    localparam int unsigned W      = 4;
    localparam int unsigned H      = 2;
    localparam int unsigned DW     = 16;
    localparam int unsigned AW     = 18;
    localparam int unsigned NW     = 12;
    localparam int unsigned BASE_I = 115200;
    localparam int unsigned BASE_P = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          done;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wr_enable;

    int cyc = 0;
    int passed = 0;
    int total = 0;
    int wr_cnt = 0;
    int bad_wr = 0;
    int done_cnt = 0;
    int first_done = -1;
    int last_done = -1;

    logic [DW-1:0] src_mem  [NW];
    logic [DW-1:0] plan_mem [NW];
    logic [DW-1:0] exp_plan [NW];

    pixel_deinterleave #(
        .ADDR_INTERLEAVED (BASE_I),
        .ADDR_PLANAR      (BASE_P),
        .W                (W),
        .H                (H),
        .DW               (DW),
        .AW               (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .raddr     (raddr),
        .rdata     (rdata),
        .waddr     (waddr),
        .wdata     (wdata),
        .wr_enable (wr_enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM read port: data for the address presented this cycle appears next cycle.
    always @(posedge clk) begin
        int ri;
        ri = int'(raddr) - int'(BASE_I);
        if (ri >= 0 && ri < int'(NW)) rdata <= src_mem[ri];
        else                          rdata <= 16'hdead;
    end

    // SRAM write port and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        int wi;
        if (wr_enable) begin
            wr_cnt = wr_cnt + 1;
            wi = int'(waddr) - int'(BASE_P);
            if (wi >= 0 && wi < int'(NW)) plan_mem[wi] = wdata;
            else                          bad_wr = bad_wr + 1;
        end
        if (done) begin
            if (done_cnt == 0) first_done = cyc;
            last_done = cyc;
            done_cnt = done_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_cnt = 0;
        bad_wr = 0;
        done_cnt = 0;
        first_done = -1;
        last_done = -1;
        for (int j = 0; j < int'(NW); j++) plan_mem[j] = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passed++;
        total++; if (wr_enable !== 1'b0) $display("FAIL rst_wr_enable got %b want 0", wr_enable); else passed++;
        total++; if (wdata !== 16'h0000) $display("FAIL rst_wdata got %h want 0000", wdata); else passed++;
        total++; if (raddr !== AW'(BASE_I)) $display("FAIL rst_raddr got %0d want %0d", raddr, BASE_I); else passed++;
        total++; if (waddr !== AW'(BASE_P)) $display("FAIL rst_waddr got %0d want %0d", waddr, BASE_P); else passed++;
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        total++; if (raddr !== AW'(BASE_I)) $display("FAIL idle_raddr got %0d want %0d", raddr, BASE_I); else passed++;
    endtask

    task automatic test_routing();
        int cs;
        logic [AW-1:0] exp_wr_addr;
`ifdef PIXEL_DEINTERLEAVE_BGR_EN
        exp_wr_addr = AW'(BASE_P + 8);
`else
        exp_wr_addr = AW'(BASE_P);
`endif
        clear_log();
        tick();
        cs = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            case (i)
                1: begin
                    total++; if (raddr !== AW'(BASE_I)) $display("FAIL ra_raddr got %0d want %0d", raddr, BASE_I); else passed++;
                    total++; if (wr_enable !== 1'b0) $display("FAIL ra_wr_enable got %b want 0", wr_enable); else passed++;
                end
                2: begin
                    total++; if (raddr !== AW'(BASE_I + 1)) $display("FAIL rb_raddr got %0d want %0d", raddr, BASE_I + 1); else passed++;
                end
                3: begin
                    total++; if (raddr !== AW'(BASE_I + 2)) $display("FAIL rc_raddr got %0d want %0d", raddr, BASE_I + 2); else passed++;
                end
                4: begin
                    total++; if (raddr !== AW'(BASE_I)) $display("FAIL wr_raddr got %0d want %0d", raddr, BASE_I); else passed++;
                    total++; if (wr_enable !== 1'b1) $display("FAIL wr_wr_enable got %b want 1", wr_enable); else passed++;
                    total++; if (waddr !== exp_wr_addr) $display("FAIL wr_waddr got %0d want %0d", waddr, exp_wr_addr); else passed++;
                    total++; if (wdata !== 16'h1144) $display("FAIL wr_wdata got %h want 1144", wdata); else passed++;
                end
                7: begin
                    total++; if (raddr !== AW'(BASE_I + 3)) $display("FAIL pair1_raddr got %0d want %0d", raddr, BASE_I + 3); else passed++;
                end
                default: ;
            endcase
            tick();
        end
        total++; if (done_cnt !== 1) $display("FAIL run_done_count got %0d want 1", done_cnt); else passed++;
        total++; if (first_done !== cs + 25) $display("FAIL run_done_cycle got %0d want %0d", first_done, cs + 25); else passed++;
        total++; if (wr_cnt !== 12) $display("FAIL run_write_count got %0d want 12", wr_cnt); else passed++;
        total++; if (bad_wr !== 0) $display("FAIL run_stray_writes got %0d want 0", bad_wr); else passed++;
        for (int j = 0; j < int'(NW); j++) begin
            total++;
            if (plan_mem[j] !== exp_plan[j]) $display("FAIL plane_word[%0d] got %h want %h", j, plan_mem[j], exp_plan[j]);
            else passed++;
        end
    endtask

    task automatic test_reset_midrun();
        int cs;
        clear_log();
        tick();
        cs = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        reset = 1'b1;
        @(negedge clk);
        total++; if (wr_enable !== 1'b0) $display("FAIL abort_wr_enable got %b want 0", wr_enable); else passed++;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        total++; if (wr_cnt !== 1) $display("FAIL abort_write_count got %0d want 1", wr_cnt); else passed++;
        total++; if (done_cnt !== 0) $display("FAIL abort_done_count got %0d want 0", done_cnt); else passed++;
        total++; if (raddr !== AW'(BASE_I)) $display("FAIL abort_raddr got %0d want %0d", raddr, BASE_I); else passed++;
        total++; if (waddr !== AW'(BASE_P)) $display("FAIL abort_waddr got %0d want %0d", waddr, BASE_P); else passed++;

        clear_log();
        tick();
        cs = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        total++; if (first_done !== cs + 25) $display("FAIL rerun_done_cycle got %0d want %0d", first_done, cs + 25); else passed++;
        total++; if (wr_cnt !== 12) $display("FAIL rerun_write_count got %0d want 12", wr_cnt); else passed++;
        for (int j = 0; j < int'(NW); j++) begin
            total++;
            if (plan_mem[j] !== exp_plan[j]) $display("FAIL rerun_word[%0d] got %h want %h", j, plan_mem[j], exp_plan[j]);
            else passed++;
        end
    endtask

    task automatic test_start_held();
        int cs;
        clear_log();
        tick();
        cs = cyc;
        start = 1'b1;
        for (int i = 1; i <= 52; i++) begin
            tick();
            if (i == 52) start = 1'b0;
            @(negedge clk);
            if (i == 27) begin
                total++; if (raddr !== AW'(BASE_I)) $display("FAIL held_ra_raddr got %0d want %0d", raddr, BASE_I); else passed++;
            end
            if (i == 28) begin
                total++; if (raddr !== AW'(BASE_I + 1)) $display("FAIL held_rb_raddr got %0d want %0d", raddr, BASE_I + 1); else passed++;
            end
        end
        for (int i = 0; i < 30; i++) tick();
        total++; if (done_cnt !== 2) $display("FAIL held_done_count got %0d want 2", done_cnt); else passed++;
        total++; if (first_done !== cs + 25) $display("FAIL held_done1_cycle got %0d want %0d", first_done, cs + 25); else passed++;
        total++; if (last_done !== cs + 51) $display("FAIL held_done2_cycle got %0d want %0d", last_done, cs + 51); else passed++;
        total++; if (wr_cnt !== 24) $display("FAIL held_write_count got %0d want 24", wr_cnt); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        src_mem[0]  = 16'h1122; src_mem[1]  = 16'h3344; src_mem[2]  = 16'h5566;
        src_mem[3]  = 16'ha1b2; src_mem[4]  = 16'hc3d4; src_mem[5]  = 16'he5f6;
        src_mem[6]  = 16'h0102; src_mem[7]  = 16'h0304; src_mem[8]  = 16'h0506;
        src_mem[9]  = 16'hff00; src_mem[10] = 16'h00ff; src_mem[11] = 16'h8001;
`ifdef PIXEL_DEINTERLEAVE_BGR_EN
        exp_plan[0] = 16'h3366; exp_plan[1] = 16'hc3f6; exp_plan[2]  = 16'h0306; exp_plan[3]  = 16'h0001;
        exp_plan[4] = 16'h2255; exp_plan[5] = 16'hb2e5; exp_plan[6]  = 16'h0205; exp_plan[7]  = 16'h0080;
        exp_plan[8] = 16'h1144; exp_plan[9] = 16'ha1d4; exp_plan[10] = 16'h0104; exp_plan[11] = 16'hffff;
`else
        exp_plan[0] = 16'h1144; exp_plan[1] = 16'ha1d4; exp_plan[2]  = 16'h0104; exp_plan[3]  = 16'hffff;
        exp_plan[4] = 16'h2255; exp_plan[5] = 16'hb2e5; exp_plan[6]  = 16'h0205; exp_plan[7]  = 16'h0080;
        exp_plan[8] = 16'h3366; exp_plan[9] = 16'hc3f6; exp_plan[10] = 16'h0306; exp_plan[11] = 16'h0001;
`endif
        for (int j = 0; j < int'(NW); j++) plan_mem[j] = '0;

        test_reset();
        test_routing();
        test_reset_midrun();
        test_start_held();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pixel_deinterleave.md
PIXEL_DEINTERLEAVE -- requirements
Module: pixel_deinterleave

Interface
REQ-001 SHALL have parameter ADDR_INTERLEAVED, default 115200: SRAM word base of the interleaved source image.
REQ-002 SHALL have parameter ADDR_PLANAR, default 0: SRAM word base of the planar destination (R plane, then G plane, then B plane).
REQ-003 SHALL have parameters W=320, H=240, DW=16 and AW=18, giving image width, image height, data width and address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: requests one full-image conversion.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when the conversion completes.
REQ-008 SHALL have port raddr, output, AW bits: SRAM read address.
REQ-009 SHALL have port rdata, input, DW bits: SRAM read data, valid exactly 1 cycle after the matching raddr.
REQ-010 SHALL have ports waddr (output, AW bits), wdata (output, DW bits) and wr_enable (output, 1 bit): SRAM write port; a write occurs in each cycle wr_enable is high.

Function
REQ-011 SHALL process pixel pairs k = 0..P-1, where P = W*H/2; W*H even is a legal-parameter precondition.
REQ-012 SHALL read source words S0, S1 and S2 for pair k at ADDR_INTERLEAVED+3k+{0,1,2}; the layout is S0={R0,G0}, S1={B0,R1}, S2={G1,B1}, first sample in [15:8].
REQ-013 SHALL write {R0,R1} to ADDR_PLANAR+k, {G0,G1} to ADDR_PLANAR+P+k, and {B0,B1} to ADDR_PLANAR+2P+k.
REQ-014 SHALL use FSM states IDLE, RA, RB, RC, WR, WG, WB and DONE.
REQ-015 SHALL take these transitions: IDLE->RA on start; RA->RB->RC->WR->WG->WB unconditionally; WB->RA if k<P-1, else WB->DONE; DONE->IDLE.
REQ-016 SHALL drive raddr with source words 0, 1 and 2 of pair k in RA, RB and RC; S0 is latched in RB, S1 in RC, and S2 in WR.
REQ-017 SHALL assert wr_enable only in WR, WG and WB.
REQ-018 SHALL build write data from the bytes latched in the current cycle: WR writes {S0[15:8],S1[7:0]}, WG writes {S0[7:0],S2[15:8]}, and WB writes {S1[15:8],S2[7:0]}.
REQ-019 SHALL take 6 cycles per pair; start sampled in cycle n gives the first raddr in cycle n+1 and done high only in cycle n+1+6P.
REQ-020 SHALL ignore start outside IDLE; start high during the DONE cycle SHALL have no effect.
REQ-021 SHALL increment pair counter k in WB and SHALL clear it in IDLE; the counter never wraps past P-1.
REQ-022 SHALL compute all addresses modulo 2^AW; parameter sets whose regions overflow AW bits are illegal.
REQ-023 SHALL hold raddr at ADDR_INTERLEAVED+3k outside RA, RB and RC, and SHALL hold waddr and wdata at their last values when wr_enable is low.

Reset
REQ-024 SHALL, on reset, enter IDLE, clear k and the latches, and set done=0, wr_enable=0, wdata=0, raddr=ADDR_INTERLEAVED and waddr=ADDR_PLANAR.
REQ-025 SHALL, when reset is asserted mid-conversion, suppress any write in that same cycle, abandon the image, and not pulse done.
REQ-026 SHALL give reset priority over start.

Configuration
REQ-027 SHALL, with PIXEL_DEINTERLEAVE_BGR_EN defined, treat the source order as B,G,R, i.e. S0={B0,G0}, S1={R0,B1}, S2={G1,R1}, and route bytes so that planar R, G and B contents match REQ-013.
REQ-028 SHALL, without PIXEL_DEINTERLEAVE_BGR_EN, use RGB source order only; timing SHALL be identical in both builds.

Structure
REQ-029 SHALL take the FSM state encoding and a plane-size helper constant (P = W*H/2) from the shared package pixel_pkg.
REQ-030 SHALL split out one sub-module, deinterleave_datapath, holding the pair counter, S0/S1/S2 latches, address generation and wdata muxing; the FSM SHALL remain in pixel_deinterleave.

Verification
REQ-031 SHALL verify small-image timing: W=4, H=2, start in cycle 10 -> first raddr in cycle 11, done only in cycle 35, exactly 12 writes.
REQ-032 SHALL verify data routing: source words 0x1122, 0x3344, 0x5566 at pair 0 -> 0x1144 to ADDR_PLANAR, 0x2255 to ADDR_PLANAR+4, 0x3366 to ADDR_PLANAR+8 (W=4, H=2, so P=4).
REQ-033 SHALL verify reset mid-run: reset asserted in cycle 20 (a WG cycle) -> no write that cycle, wr_enable=0 and no done afterwards; a fresh start then completes normally.
REQ-034 SHALL verify start while busy: start held high for the whole run -> exactly one done pulse per run, with the next run beginning in the cycle after IDLE is re-entered.
REQ-035 SHALL verify the full image: W=320, H=240, random source -> 115200 writes, all planar words match the reference model, done at n+1+230400.
REQ-036 SHALL verify the BGR build: with PIXEL_DEINTERLEAVE_BGR_EN, source 0x1122, 0x3344, 0x5566 -> R word 0x3366, G word 0x2255, B word 0x1144.
